// File: rtl/mkio_tx_encoder_if.sv
// Transmit handshake and line bundle between the device blocks (master)
// and the MKIO Manchester encoder (slave).
interface mkio_tx_encoder_if;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        tx_busy;
    logic        tx_ovf;
    logic        tx_done;
    logic        line_en;
    logic        line_p;
    logic        line_n;

    modport master (
        output tx_data, tx_cd, tx_ready,
        input  tx_busy, tx_ovf, tx_done, line_en, line_p, line_n
    );

    modport slave (
        input  tx_data, tx_cd, tx_ready,
        output tx_busy, tx_ovf, tx_done, line_en, line_p, line_n
    );
endinterface

// File: rtl/mkio_tx_encoder.sv
// MKIO (GOST R 52070 / MIL-STD-1553) remote-terminal transmitter:
// Manchester-II word serialiser with a one-word holding register.
module mkio_tx_encoder #(
    parameter int CLK_PER_HALF = 16
) (
    input  logic             clk,
    input  logic             reset,
    mkio_tx_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SYNC, BITS, PARITY} state_t;

    localparam logic [7:0] HC_LAST = 8'(CLK_PER_HALF - 1);

    state_t      state, state_nx;
    logic [7:0]  hc, hc_nx;
    logic [5:0]  hidx, hidx_nx;
    logic [15:0] shreg, shreg_nx;
    logic        cd_q, cd_nx, par_q, par_nx;
    logic        tx_ready_q, rise, load, hc_wrap, lvl, done_nx;
    logic [15:0] hold_data;
    logic        hold_cd, hold_valid, ovf_q;
    logic [1:0]  done_pipe;
    logic        line_en_q, line_p_q, line_n_q;

    assign rise    = bus.tx_ready & ~tx_ready_q;
    assign hc_wrap = (hc == HC_LAST);

    // hidx counts half-bits across the whole word: 0-5 sync, 6-37 data, 38-39 parity
    always_comb begin
        state_nx = state;
        hc_nx    = hc;
        hidx_nx  = hidx;
        shreg_nx = shreg;
        cd_nx    = cd_q;
        par_nx   = par_q;
        load     = 1'b0;
        lvl      = 1'b0;
        done_nx  = 1'b0;
        if (state != IDLE) begin
            hc_nx = hc_wrap ? 8'd0 : hc + 8'd1;
            if (hc_wrap) hidx_nx = hidx + 6'd1;
        end
        case (state)
            IDLE: load = hold_valid;
            SYNC: begin
                lvl = (hidx < 6'd3) ? ~cd_q : cd_q;
                if (hc_wrap && hidx == 6'd5) state_nx = BITS;
            end
            BITS: begin
                // even half-bit carries the bit value, odd half-bit its complement
                lvl = shreg[15] ^ hidx[0];
                if (hc_wrap && hidx[0]) shreg_nx = {shreg[14:0], 1'b0};
                if (hc_wrap && hidx == 6'd37) state_nx = PARITY;
            end
            PARITY: begin
                lvl = par_q ^ hidx[0];
                if (hc_wrap && hidx == 6'd39) begin
                    done_nx  = 1'b1;
                    load     = hold_valid;
                    state_nx = IDLE;
                    hc_nx    = 8'd0;
                    hidx_nx  = 6'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (load) begin
            state_nx = SYNC;
            hc_nx    = 8'd0;
            hidx_nx  = 6'd0;
            shreg_nx = hold_data;
            cd_nx    = hold_cd;
            par_nx   = ~^hold_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hc    <= 8'd0;
            hidx  <= 6'd0;
            shreg <= 16'd0;
            cd_q  <= 1'b0;
            par_q <= 1'b0;
        end else begin
            state <= state_nx;
            hc    <= hc_nx;
            hidx  <= hidx_nx;
            shreg <= shreg_nx;
            cd_q  <= cd_nx;
            par_q <= par_nx;
        end
    end

    // holding is seen free in the cycle it is unloaded, so a coincident rise is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ready_q <= 1'b0;
            hold_data  <= 16'd0;
            hold_cd    <= 1'b0;
            hold_valid <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            tx_ready_q <= bus.tx_ready;
            ovf_q      <= 1'b0;
            if (rise && (!hold_valid || load)) begin
                hold_data  <= bus.tx_data;
                hold_cd    <= bus.tx_cd;
                hold_valid <= 1'b1;
            end else begin
                if (load) hold_valid <= 1'b0;
                if (rise) ovf_q <= 1'b1;
            end
        end
    end

    // line lags the counters by one clock; done is held back one more so it follows the last half-bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_en_q <= 1'b0;
            line_p_q  <= 1'b0;
            line_n_q  <= 1'b0;
            done_pipe <= 2'b00;
        end else begin
            line_en_q <= (state != IDLE);
            line_p_q  <= (state != IDLE) & lvl;
            line_n_q  <= (state != IDLE) & ~lvl;
            done_pipe <= {done_pipe[0], done_nx};
        end
    end

    assign bus.tx_busy = hold_valid;
    assign bus.tx_ovf  = ovf_q;
    assign bus.tx_done = done_pipe[1];
    assign bus.line_en = line_en_q;
    assign bus.line_p  = line_p_q;
    assign bus.line_n  = line_n_q;
endmodule

// File: tb/tb_mkio_tx_encoder.sv
// Directed bench for mkio_tx_encoder: expected words queued at request time,
// captured line waveforms compared against a Manchester-II reference.
module tb_mkio_tx_encoder;
    localparam int CPH = 16;
    localparam int W   = 40 * CPH;

    logic clk;
    logic reset;
    mkio_tx_encoder_if bus();

    mkio_tx_encoder #(.CLK_PER_HALF(CPH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // monitor state (written only by the monitor process)
    int           cyc = 0, run = 0, last_run = 0;
    int           n_done = 0, n_ovf = 0, done_bad = 0, pol_err = 0, partial = 0;
    int           last_done = 0, prev_done = 0;
    int           n_obs = 0;
    logic [W-1:0] cap;
    logic [W-1:0] obs_mem [0:15];

    // stimulus-side scoreboard
    logic [16:0]  exp_q[$];
    int           rd = 0;

    function automatic logic [W-1:0] expand(input logic [16:0] w);
        logic [39:0]  hb;
        logic [15:0]  d;
        logic         p;
        logic [W-1:0] wave;
        d = w[15:0];
        p = ~^d;
        for (int i = 0; i < 6; i++) hb[i] = w[16] ? (i >= 3) : (i < 3);
        for (int b = 0; b < 16; b++) begin
            hb[6 + 2*b]     = d[15-b];
            hb[6 + 2*b + 1] = ~d[15-b];
        end
        hb[38] = p;
        hb[39] = ~p;
        for (int i = 0; i < W; i++) wave[i] = hb[i / CPH];
        return wave;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                run = 0;
            end else begin
                if (bus.tx_done) begin
                    n_done++;
                    prev_done = last_done;
                    last_done = cyc;
                    if (!(run > 0 && run % W == 0)) done_bad++;
                end
                if (bus.tx_ovf) n_ovf++;
                if (bus.line_en === 1'b1) begin
                    if (bus.line_n !== ~bus.line_p) pol_err++;
                end else if (bus.line_p !== 1'b0 || bus.line_n !== 1'b0) begin
                    pol_err++;
                end
                if (bus.line_en === 1'b1) begin
                    cap[run % W] = bus.line_p;
                    run++;
                    if (run % W == 0 && n_obs < 16) begin
                        obs_mem[n_obs] = cap;
                        n_obs++;
                    end
                end else if (run != 0) begin
                    last_run = run;
                    if (run % W != 0) partial++;
                    run = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [15:0] d, input logic c, input bit accept);
        bus.tx_data  = d;
        bus.tx_cd    = c;
        bus.tx_ready = 1'b1;
        if (accept) exp_q.push_back({c, d});
        tick();
        bus.tx_ready = 1'b0;
        bus.tx_data  = ~d;
        bus.tx_cd    = ~c;
        tick();
    endtask

    task automatic wait_idle(input int target, input string tag);
        int k;
        k = 0;
        while (!(n_done >= target && bus.line_en === 1'b0 && bus.tx_busy === 1'b0) && k < 4000) begin
            tick();
            k++;
        end
        total++;
        assert (k < 4000) else begin
            bad++;
            $error("FAIL %s timeout got=%0d cycles exp=<4000", tag, k);
        end
    endtask

    task automatic drain();
        logic [W-1:0] e;
        while (rd < n_obs) begin
            e = (exp_q.size() == 0) ? '0 : expand(exp_q.pop_front());
            total++;
            assert (obs_mem[rd] === e) else begin
                bad++;
                $error("FAIL word%0d got=%h exp=%h", rd, obs_mem[rd], e);
            end
            rd++;
        end
    endtask

    initial begin
        int d0, o0;
        reset        = 1'b1;
        bus.tx_data  = 16'h0;
        bus.tx_cd    = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_line_en", 32'(bus.line_en), 32'd0);
        chk("rst_line_p",  32'(bus.line_p),  32'd0);
        chk("rst_line_n",  32'(bus.line_n),  32'd0);
        chk("rst_busy",    32'(bus.tx_busy), 32'd0);
        chk("rst_done",    32'(bus.tx_done), 32'd0);
        chk("rst_ovf",     32'(bus.tx_ovf),  32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // status word, tx_ready held 3 clocks, latency checks
        d0 = n_done; o0 = n_ovf;
        bus.tx_data = 16'h0800; bus.tx_cd = 1'b0; bus.tx_ready = 1'b1;
        exp_q.push_back({1'b0, 16'h0800});
        tick();
        chk("lat1_busy", 32'(bus.tx_busy), 32'd1);
        chk("lat1_en",   32'(bus.line_en), 32'd0);
        tick();
        chk("lat2_busy", 32'(bus.tx_busy), 32'd0);
        chk("lat2_en",   32'(bus.line_en), 32'd0);
        tick();
        chk("lat3_en",   32'(bus.line_en), 32'd1);
        chk("lat3_p",    32'(bus.line_p),  32'd1);
        bus.tx_ready = 1'b0;
        bus.tx_data  = 16'hDEAD;
        wait_idle(d0 + 1, "status");
        chk("status_len",  32'(last_run), 32'(W));
        chk("status_done", 32'(n_done - d0), 32'd1);
        chk("status_ovf",  32'(n_ovf - o0), 32'd0);
        drain();

        // data word, all ones
        d0 = n_done;
        req(16'hFFFF, 1'b1, 1'b1);
        wait_idle(d0 + 1, "data");
        chk("data_len", 32'(last_run), 32'(W));
        drain();

        // back-to-back: second request as soon as busy falls
        d0 = n_done;
        req(16'hA5C3, 1'b0, 1'b1);
        chk("b2b_busy", 32'(bus.tx_busy), 32'd0);
        req(16'h1234, 1'b1, 1'b1);
        wait_idle(d0 + 2, "b2b");
        chk("b2b_len",     32'(last_run), 32'(2 * W));
        chk("b2b_done",    32'(n_done - d0), 32'd2);
        chk("b2b_spacing", 32'(last_done - prev_done), 32'(W));
        drain();

        // overflow: three extra requests while holding is full
        d0 = n_done; o0 = n_ovf;
        req(16'h0F0F, 1'b0, 1'b1);
        req(16'h8001, 1'b1, 1'b1);
        chk("ovf_busy", 32'(bus.tx_busy), 32'd1);
        req(16'h5555, 1'b0, 1'b0);
        req(16'hAAAA, 1'b1, 1'b0);
        req(16'h7777, 1'b0, 1'b0);
        chk("ovf_count_mid", 32'(n_ovf - o0), 32'd3);
        wait_idle(d0 + 2, "ovf");
        chk("ovf_count", 32'(n_ovf - o0), 32'd3);
        chk("ovf_done",  32'(n_done - d0), 32'd2);
        drain();

        // reset at half-bit 20
        req(16'hC00C, 1'b0, 1'b0);
        begin
            int k;
            k = 0;
            while (run < 20 * CPH && k < 2000) begin tick(); k++; end
            chk("rst_mid_reach", 32'(k < 2000), 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("rstmid_en",   32'(bus.line_en), 32'd0);
        chk("rstmid_p",    32'(bus.line_p),  32'd0);
        chk("rstmid_n",    32'(bus.line_n),  32'd0);
        chk("rstmid_busy", 32'(bus.tx_busy), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        d0 = n_done;
        req(16'h3C96, 1'b1, 1'b1);
        wait_idle(d0 + 1, "post_reset");
        chk("post_len", 32'(last_run), 32'(W));
        drain();

        chk("words",    32'(n_obs), 32'd7);
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        chk("done_pos", 32'(done_bad), 32'd0);
        chk("polarity", 32'(pol_err), 32'd0);
        chk("partial",  32'(partial), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
